// File: rtl/ex_mem_buf.sv
// ex_mem_buf: EX->MEM pipeline buffer; every mem_* output comes from the head register.
// Define EX_MEM_SKID_EN for a two-entry skid buffer; otherwise a single-entry register slice.
module ex_mem_buf #(
  parameter int DW = 64
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [DW-1:0] ex_alu_result,
  input  logic [DW-1:0] ex_dmem_write_data,
  input  logic [31:0]   ex_pc_plus_4,
  input  logic [4:0]    ex_rd,
  input  logic [1:0]    ex_wb_select,
  input  logic [7:0]    ex_write_width,
  input  logic          ex_is_write_dmem,
  input  logic          flush,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [DW-1:0] mem_alu_result,
  output logic [DW-1:0] mem_dmem_write_data,
  output logic [31:0]   mem_pc_plus_4,
  output logic [4:0]    mem_rd,
  output logic [1:0]    mem_wb_select,
  output logic [7:0]    mem_write_width,
  output logic          mem_is_write_dmem,
  output logic [1:0]    mem_count
);

  localparam int PW = 2 * DW + 48;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] ex_payload;
  logic          accept, rel;

  assign ex_payload = {ex_alu_result, ex_dmem_write_data, ex_pc_plus_4, ex_rd,
                       ex_wb_select, ex_write_width, ex_is_write_dmem};

  assign mem_valid = (state_reg != EMPTY);
  assign mem_count = state_reg;

`ifdef EX_MEM_SKID_EN
  logic [PW-1:0] skid_reg, skid_next;
  // Ready depends only on registered occupancy, breaking the mem_ready->ex_ready path.
  assign ex_ready = (state_reg != TWO);
`else
  assign ex_ready = !mem_valid || mem_ready;
`endif

  assign accept = ex_valid && ex_ready;
  assign rel    = mem_valid && mem_ready;

  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
`ifdef EX_MEM_SKID_EN
    skid_next  = skid_reg;
`endif
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            state_next = ONE;
            head_next  = ex_payload;
          end
        end
        ONE: begin
`ifdef EX_MEM_SKID_EN
          if (accept && rel) begin
            head_next = ex_payload;
          end else if (accept) begin
            state_next = TWO;
            skid_next  = ex_payload;
          end else if (rel) begin
            state_next = EMPTY;
          end
`else
          // With a single entry an accept while occupied implies a same-cycle release.
          if (accept) begin
            head_next = ex_payload;
          end else if (rel) begin
            state_next = EMPTY;
          end
`endif
        end
        TWO: begin
`ifdef EX_MEM_SKID_EN
          if (rel) begin
            state_next = ONE;
            head_next  = skid_reg;
          end
`else
          state_next = EMPTY;
`endif
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_reg <= EMPTY;
      head_reg  <= '0;
`ifdef EX_MEM_SKID_EN
      skid_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      head_reg  <= head_next;
`ifdef EX_MEM_SKID_EN
      skid_reg  <= skid_next;
`endif
    end
  end

  assign mem_alu_result      = head_reg[PW-1 -: DW];
  assign mem_dmem_write_data = head_reg[DW+47 -: DW];
  assign mem_pc_plus_4       = head_reg[47:16];
  assign mem_wb_select       = head_reg[10:9];
  assign mem_write_width     = head_reg[8:1];
  // Destination and store strobe are squashed so an empty slot can never write.
  assign mem_rd              = mem_valid ? head_reg[15:11] : 5'd0;
  assign mem_is_write_dmem   = mem_valid && head_reg[0];

endmodule

// File: doc/ex_mem_buf.md
EX_MEM_BUF -- requirements
Module: ex_mem_buf

Interface
REQ-001 SHALL have parameter DW, default 64, datapath width for ALU result and store data.
REQ-002 SHALL have port sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port sys_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ex_valid  input  1  EX stage presents a valid result this cycle.
REQ-005 SHALL have port ex_ready  output  1  buffer accepts the EX payload this cycle.
REQ-006 SHALL have payload inputs: ex_alu_result DW, ex_dmem_write_data DW, ex_pc_plus_4 32, ex_rd 5, ex_wb_select 2, ex_write_width 8, ex_is_write_dmem 1.
REQ-007 SHALL have port flush  input  1  control-hazard kill of all buffered entries.
REQ-008 SHALL have port mem_valid  output  1  head entry valid toward MEM.
REQ-009 SHALL have port mem_ready  input  1  MEM consumes head entry this cycle.
REQ-010 SHALL have payload outputs mem_alu_result, mem_dmem_write_data, mem_pc_plus_4, mem_rd, mem_wb_select, mem_write_width, mem_is_write_dmem, widths matching REQ-006.
REQ-011 SHALL have port mem_count  output  2  number of occupied entries (0..2).

Function
REQ-012 SHALL accept a payload when ex_valid && ex_ready; SHALL release head when mem_valid && mem_ready.
REQ-013 SHALL deliver payloads to MEM in acceptance order, no loss, no duplication.
REQ-014 SHALL drive all mem_* payload outputs directly from the head entry register (no combinational path from ex_* to mem_*).
REQ-015 SHALL force mem_is_write_dmem=0 and mem_rd=0 whenever mem_valid=0.
REQ-016 SHALL have latency 1 cycle: payload accepted at edge N appears with mem_valid=1 after edge N when buffer was empty.
REQ-017 SHALL implement states EMPTY(count 0), ONE(count 1), TWO(count 2); mem_valid = (count!=0).
REQ-018 EMPTY: accept -> ONE; else stay.
REQ-019 ONE: accept only -> TWO (new entry into skid slot); release only -> EMPTY; accept and release same cycle -> ONE with new payload in head.
REQ-020 TWO: ex_ready=0; release -> ONE with skid entry moved to head; else stay, head held stable.
REQ-021 SHALL hold head payload unchanged while mem_valid=1 and mem_ready=0.
REQ-022 flush=1 SHALL force next state EMPTY regardless of ex_valid/mem_ready; an entry offered in the flush cycle SHALL be discarded; flush dominates all simultaneous events.
REQ-023 ex_valid SHALL be ignored (no state change) when ex_ready=0.

Reset
REQ-024 sys_rst=0 SHALL asynchronously set count=0, mem_valid=0, all payload registers to 0.
REQ-025 After reset release, ex_ready SHALL be 1 (SKID build) and first accept SHALL occur no earlier than the first rising edge with sys_rst=1.
REQ-026 Reset mid-transfer SHALL discard all entries; no partial entry survives.

Configuration
REQ-027 Macro EX_MEM_SKID_EN defined: two-entry buffer per REQ-017..020; ex_ready = (count!=2), derived from registered state only.
REQ-028 EX_MEM_SKID_EN undefined: single entry, TWO unreachable, mem_count in {0,1}; ex_ready = !mem_valid || mem_ready (combinational); accept and release same cycle replaces head.

Verification
REQ-029 Reset, then ex_valid=1, ex_alu_result=64'h1234, ex_rd=5, mem_ready=1 -> one cycle later mem_valid=1, mem_alu_result=64'h1234, mem_rd=5, mem_count=1.
REQ-030 mem_ready=0, three back-to-back offers A=1,B=2,C=3 (SKID) -> A,B accepted, ex_ready=0 while C held, mem_count=2, mem_alu_result stays 1; raise mem_ready -> outputs 1,2,3 in order on consecutive cycles.
REQ-031 Streaming ex_valid=1, mem_ready=1 for 8 cycles, results 0..7 -> mem_count stays 1, outputs 0..7 one per cycle, no bubbles.
REQ-032 Count=2, flush=1 with ex_valid=1 same cycle -> next cycle mem_valid=0, mem_count=0, mem_is_write_dmem=0, mem_rd=0; offered entry never appears.
REQ-033 Count=2, sys_rst pulsed low between edges -> mem_valid=0 and mem_count=0 immediately, payload outputs 0.
REQ-034 EX_MEM_SKID_EN undefined, mem_valid=1, mem_ready=0 -> ex_ready=0 same cycle; mem_ready=1 -> ex_ready=1 same cycle and new payload in head next cycle.
